// File: rtl/mac_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : mac_tcdm_responder
// Brief    : Single-port TCDM slave with grant handshake, 1-cycle response,
//            backdoor load, transaction counters and sticky address error.
//            Optional pseudo-random stalls: define MAC_TCDM_RESP_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tcdm_responder #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [15:0]            LFSR_SEED  = 16'hACE1,
    parameter int unsigned            MAX_STALL  = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         enable_i,
    input  logic                         req_i,
    input  logic [ADDR_WIDTH-1:0]        add_i,
    input  logic                         wen_i,
    input  logic [DATA_WIDTH/8-1:0]      be_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         gnt_o,
    output logic                         r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_data_o,
    input  logic [3:0]                   stall_mask_i,
    input  logic                         bd_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_addr_i,
    input  logic [DATA_WIDTH-1:0]        bd_data_i,
    output logic [31:0]                  n_reads_o,
    output logic [31:0]                  n_writes_o,
    output logic                         err_o
);

    localparam int unsigned             c_IDX_W    = $clog2(MEM_WORDS);
    localparam logic [DATA_WIDTH-1:0]   c_BAD_DATA = DATA_WIDTH'(32'hDEADBEEF);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_in_range;
    logic                  w_stall;
    logic                  w_xact;
    logic                  w_bus_wr;
    logic                  w_unused_bits;

    assign w_offset   = add_i - BASE_ADDR;
    assign w_idx      = w_offset[c_IDX_W+1:2];
    assign w_in_range = (add_i >= BASE_ADDR) && ((w_offset >> 2) < ADDR_WIDTH'(MEM_WORDS));

    // Reset gating keeps the grant low while the block is held in reset.
    assign gnt_o    = rst_ni & req_i & enable_i & ~w_stall;
    assign w_xact   = req_i & gnt_o;
    assign w_bus_wr = w_xact & ~wen_i & w_in_range;

`ifdef MAC_TCDM_RESP_STALL_EN
    localparam int unsigned c_CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

    logic [15:0]        r_lfsr;
    logic [c_CNT_W-1:0] r_stall_cnt;
    logic               w_fb;

    assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_stall = (|(r_lfsr[3:0] & stall_mask_i)) && (r_stall_cnt < c_CNT_W'(MAX_STALL));
    assign w_unused_bits = ^w_offset[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr      <= LFSR_SEED;
            r_stall_cnt <= '0;
        end else if (clear_i) begin
            r_lfsr      <= LFSR_SEED;
            r_stall_cnt <= '0;
        end else begin
            if (enable_i) begin
                r_lfsr <= {r_lfsr[14:0], w_fb};
            end
            // Count only consecutive refused requests; a disabled cycle holds the run.
            if (!req_i || gnt_o) begin
                r_stall_cnt <= '0;
            end else if (enable_i) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
`else
    assign w_stall       = 1'b0;
    assign w_unused_bits = ^{w_offset[1:0], stall_mask_i};
`endif

    // Bus write is applied after the backdoor so it wins on a same-word collision.
    always_ff @(posedge clk_i) begin
        if (bd_we_i) begin
            r_mem[bd_addr_i] <= bd_data_i;
        end
        if (w_bus_wr) begin
            for (int k = 0; k < DATA_WIDTH/8; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o  <= 1'b0;
            r_data_o   <= '0;
            n_reads_o  <= '0;
            n_writes_o <= '0;
            err_o      <= 1'b0;
        end else if (clear_i) begin
            r_valid_o  <= 1'b0;
            r_data_o   <= '0;
            n_reads_o  <= '0;
            n_writes_o <= '0;
            err_o      <= 1'b0;
        end else if (w_xact) begin
            r_valid_o <= 1'b1;
            if (wen_i) begin
                r_data_o  <= w_in_range ? r_mem[w_idx] : c_BAD_DATA;
                n_reads_o <= n_reads_o + 32'd1;
            end else begin
                r_data_o   <= '0;
                n_writes_o <= n_writes_o + 32'd1;
            end
            if (!w_in_range) begin
                err_o <= 1'b1;
            end
        end else begin
            r_valid_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tcdm_responder
// Brief    : Self-checking bench for mac_tcdm_responder against a word-array
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tcdm_responder;

    localparam int MEM_WORDS = 1024;
    localparam int MAX_STALL = 7;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i, enable_i, req_i, wen_i, bd_we_i;
    logic [31:0] add_i, data_i, bd_data_i;
    logic [3:0]  be_i, stall_mask_i;
    logic [9:0]  bd_addr_i;
    logic        gnt_o, r_valid_o, err_o;
    logic [31:0] r_data_o, n_reads_o, n_writes_o;

    mac_tcdm_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
        .stall_mask_i(stall_mask_i), .bd_we_i(bd_we_i), .bd_addr_i(bd_addr_i),
        .bd_data_i(bd_data_i), .n_reads_o(n_reads_o), .n_writes_o(n_writes_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [MEM_WORDS];
    int unsigned exp_reads, exp_writes;
    logic        exp_err, exp_valid;
    logic [31:0] exp_data;
    int          run;
    int          grants;
    logic        g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, judge the grant mid-cycle, predict, check after the edge.
    task automatic step(input logic req, input logic [31:0] addr, input logic wen,
                        input logic [3:0] be, input logic [31:0] data, input logic en,
                        input logic clr, input logic bdwe, input logic [9:0] bda,
                        input logic [31:0] bdd, output logic gg);
        logic        in_rng;
        logic [9:0]  idx;
        logic        xact;
        req_i = req; add_i = addr; wen_i = wen; be_i = be; data_i = data;
        enable_i = en; clear_i = clr; bd_we_i = bdwe; bd_addr_i = bda; bd_data_i = bdd;
        #4;
        gg = gnt_o;
`ifdef MAC_TCDM_RESP_STALL_EN
        if (stall_mask_i == 4'h0) begin
            check("gnt", gg, req & en);
        end else begin
            check("gnt_legal", gg & ~(req & en), 0);
            if (req && en && !gg) run++;
            else if (!req || gg) run = 0;
            check("stall_run_bound", (run <= MAX_STALL), 1);
        end
`else
        check("gnt", gg, req & en);
`endif
        in_rng = (addr < MEM_WORDS * 4);
        idx    = addr[11:2];
        xact   = req & gg;
        if (clr) begin
            exp_valid = 0; exp_data = 0; exp_reads = 0; exp_writes = 0; exp_err = 0;
        end else if (xact) begin
            exp_valid = 1;
            if (wen) begin
                exp_data = in_rng ? mem_m[idx] : 32'hDEADBEEF;
                exp_reads++;
            end else begin
                exp_data = 0;
                exp_writes++;
            end
            if (!in_rng) exp_err = 1;
        end else begin
            exp_valid = 0;
        end
        if (bdwe) mem_m[bda] = bdd;
        if (xact && !wen && in_rng)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem_m[idx][8*k +: 8] = data[8*k +: 8];
        @(posedge clk_i);
        #1;
        check("r_valid", r_valid_o, exp_valid);
        if (exp_valid || clr) check("r_data", r_data_o, exp_data);
        check("n_reads", n_reads_o, exp_reads);
        check("n_writes", n_writes_o, exp_writes);
        check("err", err_o, exp_err);
    endtask

    task automatic idle();
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, g);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1, a, 1, 0, 0, 1, 0, 0, 0, 0, g);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1, a, 0, be, d, 1, 0, 0, 0, 0, g);
    endtask

    task automatic bd(input logic [9:0] a, input logic [31:0] d);
        step(0, 0, 1, 0, 0, 1, 0, 1, a, d, g);
    endtask

    initial begin
        rst_ni = 0; clear_i = 0; enable_i = 1; req_i = 0; wen_i = 1; add_i = 0;
        be_i = 0; data_i = 0; bd_we_i = 0; bd_addr_i = 0; bd_data_i = 0; stall_mask_i = 0;
        exp_reads = 0; exp_writes = 0; exp_err = 0; exp_valid = 0; exp_data = 0; run = 0;
        #2;
        check("rst_gnt", gnt_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_r_data", r_data_o, 0);
        check("rst_n_reads", n_reads_o, 0);
        check("rst_n_writes", n_writes_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1;

        // Backdoor preload, then four back-to-back reads
        for (int i = 0; i < 64; i++) bd(i[9:0], (i < 4) ? 32'h11111111 * (i + 1) : $urandom);
        for (int i = 0; i < 4; i++) rd(i * 4);
        check("plan_reads4", n_reads_o, 4);

        // Partial write then read-after-write
        wr(0, 4'b0101, 32'hAABBCCDD);
        rd(0);
        check("plan_partial_write", r_data_o, 32'h11BB11DD);

        // Out-of-range read, sticky error, then clear
        rd(MEM_WORDS * 4);
        rd(8);
        check("plan_err_sticky", err_o, 1);
        step(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, g);
        check("plan_clear_reads", n_reads_o, 0);

        // Same-cycle backdoor and bus write to word 5
        step(1, 20, 0, 4'hF, 32'h2, 1, 0, 1, 10'd5, 32'h1, g);
        rd(20);
        check("plan_bd_collision", r_data_o, 32'h2);

        // Clear with a same-cycle write: no response, write commits
        step(1, 24, 0, 4'hF, 32'hCAFE0006, 1, 1, 0, 0, 0, g);
        rd(24);
        check("plan_clear_write_commit", r_data_o, 32'hCAFE0006);

        // Dense stall mask with request held for 200 grants
        step(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, g);
        stall_mask_i = 4'hF; grants = 0; run = 0;
        for (int i = 0; i < 4000 && grants < 200; i++) begin
            rd((grants % 64) * 4);
            if (g) grants++;
        end
        check("stall_grants", grants, 200);
        check("stall_n_reads", n_reads_o, 200);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            stall_mask_i = 4'($urandom);
            if ($urandom_range(0, 15) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'h1000 + $urandom_range(0, 255) * 4 : 32'hFFFFFFF0;
            else
                a = $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) != 0, 4'($urandom),
                 $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 7) == 0, 10'($urandom_range(0, 63)), $urandom, g);
        end
        stall_mask_i = 0;
        idle();

        // Error set, grant pending, then asynchronous reset mid-cycle
        rd(MEM_WORDS * 4 + 8);
        rd(12);
        check("pre_rst_valid", r_valid_o, 1);
        req_i = 1; enable_i = 1; wen_i = 1; add_i = 12;
        rst_ni = 0;
        #1;
        check("arst_gnt", gnt_o, 0);
        check("arst_r_valid", r_valid_o, 0);
        check("arst_r_data", r_data_o, 0);
        check("arst_n_reads", n_reads_o, 0);
        check("arst_n_writes", n_writes_o, 0);
        check("arst_err", err_o, 0);
        exp_reads = 0; exp_writes = 0; exp_err = 0; exp_valid = 0; exp_data = 0; run = 0;
        req_i = 0;
        @(posedge clk_i); #1;
        rst_ni = 1;
        rd(12);
        check("post_rst_n_reads", n_reads_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_tcdm_responder.md
# mac_tcdm_responder

Single-port TCDM slave that answers the TCDM master port of the MAC streamer in block-level and engine-level benches, and serves as a scratch memory in standalone MAC configurations. Each request is accepted with a grant handshake, optionally delayed by a bounded pseudo-random stall generator. The response (r_valid/r_data) is returned exactly one cycle after each grant. The block also provides a backdoor load port, transaction counters and a sticky address-error flag.

## Interface
- DATA_WIDTH, 32, bus data width; must be 32
- ADDR_WIDTH, 32, byte address width
- MEM_WORDS, 1024, memory depth in 32-bit words; power of two
- BASE_ADDR, 32'h0, byte address mapped to word 0
- LFSR_SEED, 16'hACE1, stall LFSR reset and clear value; must be nonzero
- MAX_STALL, 7, maximum consecutive stalled cycles before a grant is forced

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear of counters, response register, stall state and error flag
- enable_i  in  1  when low, no grants are given and the LFSR holds
- req_i  in  1  TCDM request
- add_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1 = read, 0 = write
- be_i  in  4  byte enables, applied to writes only
- data_i  in  32  write data
- gnt_o  out  1  grant, combinational
- r_valid_o  out  1  response valid, registered
- r_data_o  out  32  read data, registered
- stall_mask_i  in  4  stall density control
- bd_we_i  in  1  backdoor write strobe
- bd_addr_i  in  $clog2(MEM_WORDS)  backdoor word index
- bd_data_i  in  32  backdoor write data
- n_reads_o  out  32  granted read count
- n_writes_o  out  32  granted write count
- err_o  out  1  sticky out-of-range flag

## Operation
- Word index is computed as idx = (add_i - BASE_ADDR) >> 2.
  - In range when add_i >= BASE_ADDR and idx < MEM_WORDS.
  - add_i[1:0] is ignored.
- Grant rule: gnt_o = req_i & enable_i & ~stall.
- A granted transaction is any cycle with req_i & gnt_o.
- Granted write, in range: mem[idx] byte lanes with be_i[k]=1 take data_i[8k+7:8k] at the clock edge. be_i=0 leaves the word unchanged.
- Granted read, in range: r_data_o <= mem[idx] at the clock edge.
- Granted write response: r_data_o <= '0.
- Every granted transaction sets r_valid_o <= 1 for the next cycle, reads and writes alike. Otherwise r_valid_o <= 0.
- Out-of-range access:
  - the transaction is still granted and answered;
  - read data is 32'hDEADBEEF;
  - writes are dropped;
  - err_o is set and stays set until clear_i or reset.
- Counters increment on each granted read or write respectively. They wrap at 2^32.
- Backdoor write: mem[bd_addr_i] <= bd_data_i with all bytes written, independent of enable_i. If a bus write targets the same word in the same cycle, the bus write takes effect.
- Memory contents are not reset and not cleared.

## Timing
- Reset values:
  - gnt_o = 0, r_valid_o = 0, r_data_o = 0;
  - n_reads_o = 0, n_writes_o = 0, err_o = 0;
  - LFSR = LFSR_SEED, stall counter = 0.
- Latency: r_valid_o follows gnt_o by exactly 1 cycle, which back-to-back grants give one response per cycle.
- Read-after-write: a read granted in cycle N+1 to a word written in cycle N returns the new data in cycle N+2.
- req_i dropped while stalled: no transaction takes place and no response is produced. The master is not required to hold req_i.
- clear_i has priority over a same-cycle grant:
  - the response is suppressed (r_valid_o = 0 next cycle);
  - counters do not increment;
  - a write to memory still commits.
- Reset mid-transaction: a pending response is discarded and r_valid_o goes to 0 asynchronously.

## Configuration
- MAC_TCDM_RESP_STALL_EN defined:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11; it advances every cycle that enable_i is high.
  - stall = |(lfsr[3:0] & stall_mask_i) & (stall_cnt < MAX_STALL).
  - stall_cnt counts consecutive cycles with req_i & ~gnt_o & enable_i. It resets to 0 on a grant, on req_i low, or on clear_i.
  - stall_mask_i = 0 never stalls.
- MAC_TCDM_RESP_STALL_EN undefined:
  - stall = 0; stall_mask_i is ignored; no LFSR or stall counter is instantiated.
  - gnt_o = req_i & enable_i.

## Test plan
- Backdoor-load words 0..3 with 0x11111111..0x44444444, then 4 back-to-back reads at 0x0, 0x4, 0x8, 0xC with mask 0 -> gnt_o=1 every cycle; r_valid_o in cycles 1..4 with the loaded data; n_reads_o=4.
- Write 0xAABBCCDD with be_i=4'b0101 over 0x11111111 at 0x0, then read 0x0 -> 0x11BB11DD returned 2 cycles after the write grant; r_valid_o asserted after the write with r_data_o=0.
- With the stall macro defined, stall_mask_i=4'hF, and req_i held high for 200 grants -> no run of stalled cycles longer than 7; every grant is followed by r_valid_o; n_reads_o=200.
- Read at MEM_WORDS*4 -> r_data_o=0xDEADBEEF, err_o=1 and sticky; clear_i pulse -> err_o=0 and counters 0.
- Same-cycle backdoor write 0x1 and bus write 0x2 to word 5, then read word 5 -> 0x00000002.
- Grant in cycle N with rst_ni asserted in cycle N+1 -> r_valid_o=0 and all outputs at reset values immediately.
